// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: delay-slot aware PC redirect to fetch with CP0 exception override.
// Define BRANCH_REDIRECT_STAT_EN to build the taken/wait statistics counters.
module branch_redirect_ctrl #(
    parameter logic [31:0] RESET_TARGET = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        EXE_BranchTaken,
    input  logic [31:0] EXE_BranchTarget,
    input  logic        ID_DelaySlotValid,
    input  logic        IF_Ready,
    input  logic        EXC_Redirect,
    input  logic [31:0] EXC_Target,
    output logic        PC_RedirectValid,
    output logic [31:0] PC_RedirectTarget,
    output logic        IF_Flush,
    output logic        EXE_Stall,
    output logic [31:0] STAT_TakenCnt,
    output logic [31:0] STAT_WaitCnt
);
    typedef enum logic [1:0] {IDLE, WAIT_DS, PEND} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_tgt, w_tgt_next;
    logic        r_valid;
    logic        w_br_start;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_tgt   <= RESET_TARGET;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tgt   <= w_tgt_next;
            r_valid <= (w_next == PEND);
        end
    end
    // An exception overrides whatever the branch path was doing, in every state.
    always_comb begin
        w_next     = r_state;
        w_tgt_next = r_tgt;
        w_br_start = (r_state == IDLE) && EXE_BranchTaken && !EXC_Redirect;
        if (EXC_Redirect) begin
            w_next     = PEND;
            w_tgt_next = EXC_Target;
        end else begin
            case (r_state)
                IDLE: if (EXE_BranchTaken) begin
                    w_next     = ID_DelaySlotValid ? PEND : WAIT_DS;
                    w_tgt_next = EXE_BranchTarget;
                end
                WAIT_DS: w_next = ID_DelaySlotValid ? PEND : WAIT_DS;
                PEND:    w_next = IF_Ready ? IDLE : PEND;
                default: w_next = IDLE;
            endcase
        end
    end
    assign EXE_Stall = resetn && !EXC_Redirect && !ID_DelaySlotValid &&
                       (((r_state == IDLE) && EXE_BranchTaken) || (r_state == WAIT_DS));
    assign IF_Flush          = resetn && (r_state == PEND) && IF_Ready;
    assign PC_RedirectValid  = r_valid;
    assign PC_RedirectTarget = r_tgt;
`ifdef BRANCH_REDIRECT_STAT_EN
    logic [31:0] r_taken_cnt, r_wait_cnt;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_taken_cnt <= 32'h0;
            r_wait_cnt  <= 32'h0;
        end else begin
            r_taken_cnt <= r_taken_cnt + {31'h0, w_br_start};
            r_wait_cnt  <= r_wait_cnt + {31'h0, EXE_Stall || (r_valid && !IF_Ready)};
        end
    end
    assign STAT_TakenCnt = r_taken_cnt;
    assign STAT_WaitCnt  = r_wait_cnt;
`else
    assign STAT_TakenCnt = 32'h0;
    assign STAT_WaitCnt  = 32'h0;
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: per-cycle vector table plus a redirect-target scoreboard.
module tb_branch_redirect_ctrl;
    localparam logic [31:0] RT = 32'hBFC0_0000;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        taken = 1'b0, ds = 1'b0, ready = 1'b0, exc = 1'b0;
    logic [31:0] btgt = 32'h0, etgt = 32'h0;
    logic        valid, flush, stall;
    logic [31:0] tgt, tcnt, wcnt;
    int          n_tests = 0, n_fail = 0;
    logic [31:0] sb[$];

    branch_redirect_ctrl #(.RESET_TARGET(RT)) dut (
        .clk(clk), .resetn(resetn),
        .EXE_BranchTaken(taken), .EXE_BranchTarget(btgt),
        .ID_DelaySlotValid(ds), .IF_Ready(ready),
        .EXC_Redirect(exc), .EXC_Target(etgt),
        .PC_RedirectValid(valid), .PC_RedirectTarget(tgt),
        .IF_Flush(flush), .EXE_Stall(stall),
        .STAT_TakenCnt(tcnt), .STAT_WaitCnt(wcnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        taken;
        logic [31:0] btgt;
        logic        ds;
        logic        ready;
        logic        exc;
        logic [31:0] etgt;
        logic        e_stall;
        logic        e_flush;
        logic        e_valid;
        logic [31:0] e_tgt;
        logic        push;
    } vec_t;
    vec_t vt[27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && valid && ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: unexpected redirect to %h at %0t", tgt, $time);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (tgt !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard: redirect %h expected %h at %0t", tgt, e, $time);
                end
            end
        end
    end

    initial begin
        //        tk  btgt          ds rdy exc etgt          stl fl vl e_tgt         push
        vt[0]  = '{1, 32'hBFC0_0100, 1, 1, 0, 32'h0,         0, 0, 0, 32'h0,         1};
        vt[1]  = '{0, 32'h0,         0, 1, 0, 32'h0,         0, 1, 1, 32'hBFC0_0100, 0};
        vt[2]  = '{0, 32'h0,         0, 1, 0, 32'h0,         0, 0, 0, 32'h0,         0};
        vt[3]  = '{1, 32'h8000_1000, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0,         1};
        vt[4]  = '{1, 32'hDEAD_0000, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0,         0};
        vt[5]  = '{0, 32'h0,         0, 0, 0, 32'h0,         1, 0, 0, 32'h0,         0};
        vt[6]  = '{0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0};
        vt[7]  = '{0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 1, 32'h8000_1000, 0};
        vt[8]  = '{1, 32'hDEAD_0004, 1, 0, 0, 32'h0,         0, 0, 1, 32'h8000_1000, 0};
        vt[9]  = '{0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 1, 32'h8000_1000, 0};
        vt[10] = '{0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 1, 32'h8000_1000, 0};
        vt[11] = '{0, 32'h0,         0, 1, 0, 32'h0,         0, 1, 1, 32'h8000_1000, 0};
        vt[12] = '{0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0};
        vt[13] = '{1, 32'h8000_0000, 1, 0, 1, 32'hBFC0_0380, 0, 0, 0, 32'h0,         1};
        vt[14] = '{0, 32'h0,         0, 1, 0, 32'h0,         0, 1, 1, 32'hBFC0_0380, 0};
        vt[15] = '{0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0};
        vt[16] = '{1, 32'h8000_2000, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0,         0};
        vt[17] = '{0, 32'h0,         0, 0, 1, 32'hBFC0_0200, 0, 0, 0, 32'h0,         1};
        vt[18] = '{0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 1, 32'hBFC0_0200, 0};
        vt[19] = '{0, 32'h0,         0, 1, 1, 32'hBFC0_0380, 0, 1, 1, 32'hBFC0_0200, 1};
        vt[20] = '{0, 32'h0,         0, 1, 0, 32'h0,         0, 1, 1, 32'hBFC0_0380, 0};
        vt[21] = '{0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0};
        vt[22] = '{1, 32'h8000_3000, 1, 0, 0, 32'h0,         0, 0, 0, 32'h0,         1};
        vt[23] = '{1, 32'h8000_5000, 1, 1, 0, 32'h0,         0, 1, 1, 32'h8000_3000, 0};
        vt[24] = '{1, 32'h8000_4000, 1, 0, 0, 32'h0,         0, 0, 0, 32'h0,         1};
        vt[25] = '{0, 32'h0,         0, 1, 0, 32'h0,         0, 1, 1, 32'h8000_4000, 0};
        vt[26] = '{0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0};

        repeat (2) @(negedge clk);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_flush", {31'h0, flush}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_target", tgt, RT);
        chk("rst_tcnt", tcnt, 32'h0);
        chk("rst_wcnt", wcnt, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < 27; i++) begin
            @(posedge clk);
            #1;
            taken = vt[i].taken; btgt = vt[i].btgt; ds = vt[i].ds;
            ready = vt[i].ready; exc = vt[i].exc; etgt = vt[i].etgt;
            if (vt[i].push) sb.push_back(vt[i].exc ? vt[i].etgt : vt[i].btgt);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, vt[i].e_stall});
            chk($sformatf("v%0d_flush", i), {31'h0, flush}, {31'h0, vt[i].e_flush});
            chk($sformatf("v%0d_valid", i), {31'h0, valid}, {31'h0, vt[i].e_valid});
            if (vt[i].e_valid) chk($sformatf("v%0d_target", i), tgt, vt[i].e_tgt);
        end
        @(posedge clk);
        #1;
        taken = 0; ds = 0; ready = 0; exc = 0;
        @(negedge clk);
`ifdef BRANCH_REDIRECT_STAT_EN
        chk("stat_taken", tcnt, 32'd5);
        chk("stat_wait", wcnt, 32'd9);
`else
        chk("stat_taken_off", tcnt, 32'h0);
        chk("stat_wait_off", wcnt, 32'h0);
`endif

        // Reset asserted mid-WAIT_DS must clear everything without a clock edge.
        @(posedge clk);
        #1;
        taken = 1; btgt = 32'h8000_7000; ds = 0;
        @(negedge clk);
        chk("wds_stall0", {31'h0, stall}, 32'h1);
        @(posedge clk);
        #1;
        taken = 0;
        @(negedge clk);
        chk("wds_stall1", {31'h0, stall}, 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_stall", {31'h0, stall}, 32'h0);
        chk("arst_valid", {31'h0, valid}, 32'h0);
        chk("arst_flush", {31'h0, flush}, 32'h0);
        chk("arst_target", tgt, RT);
        chk("arst_tcnt", tcnt, 32'h0);
        chk("arst_wcnt", wcnt, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        ds = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_valid%0d", i), {31'h0, valid}, 32'h0);
            chk($sformatf("post_rst_stall%0d", i), {31'h0, stall}, 32'h0);
        end
        ds = 0;

`ifdef BRANCH_REDIRECT_STAT_EN
        @(negedge clk);
        force dut.r_taken_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_taken_cnt;
        chk("wrap_preload", tcnt, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        taken = 1; btgt = 32'h8000_6000; ds = 1;
        sb.push_back(32'h8000_6000);
        @(posedge clk);
        #1;
        taken = 0; ds = 0; ready = 1;
        @(negedge clk);
        chk("wrap_tcnt", tcnt, 32'h0);
        @(posedge clk);
        #1;
        ready = 0;
        @(negedge clk);
`endif

        chk("sb_empty", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Branch redirect controller sitting directly downstream of the EXE-stage branch resolver. It takes the resolver's taken/flush decision and the resolved target, waits for the MIPS delay-slot instruction to reach ID, and then issues a single PC redirect request to the fetch stage using a valid/ready handshake. Exception and ERET redirects from the CP0 path override any branch redirect. It also kills the wrong-path instruction sitting in IF.

## Interface
Parameters:
- RESET_TARGET, 32'h0, value held in the target register after reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- EXE_BranchTaken  in  1  taken/flush decision from the branch resolver (its ID_Flush output).
- EXE_BranchTarget  in  32  resolved branch/jump target, valid while EXE_BranchTaken=1.
- ID_DelaySlotValid  in  1  the delay-slot instruction of the EXE branch is present in ID this cycle.
- IF_Ready  in  1  fetch accepts a redirect this cycle.
- EXC_Redirect  in  1  exception/ERET redirect request; single-cycle pulse.
- EXC_Target  in  32  exception vector or EPC, valid with EXC_Redirect.
- PC_RedirectValid  out  1  redirect request to fetch.
- PC_RedirectTarget  out  32  redirect PC; stable while PC_RedirectValid=1.
- IF_Flush  out  1  kill the instruction currently in IF (wrong path).
- EXE_Stall  out  1  hold the branch in EXE (and freeze upstream) until its delay slot arrives.
- STAT_TakenCnt  out  32  taken-redirect counter (see Configuration).
- STAT_WaitCnt  out  32  redirect wait-cycle counter (see Configuration).

## Operation
- FSM states: IDLE, WAIT_DS, PEND. Registered 32-bit target register TGT.
- IDLE:
  - EXE_BranchTaken=1 and ID_DelaySlotValid=1: TGT<=EXE_BranchTarget; go to PEND.
  - EXE_BranchTaken=1 and ID_DelaySlotValid=0: TGT<=EXE_BranchTarget; go to WAIT_DS. EXE_Stall=1 combinationally in this cycle.
- WAIT_DS: EXE_Stall=1 while ID_DelaySlotValid=0. On ID_DelaySlotValid=1, EXE_Stall=0 and the FSM goes to PEND. TGT is held; EXE_BranchTaken/Target are ignored.
- PEND: PC_RedirectValid=1 and PC_RedirectTarget=TGT. When IF_Ready=1, the handshake completes, IF_Flush=1 in the same cycle, and the FSM goes to IDLE. EXE_BranchTaken is ignored, since a delay slot is never a branch.
- PC_RedirectTarget is TGT in all states and is only meaningful when valid.
- Exception override:
  - EXC_Redirect=1 in any state loads TGT<=EXC_Target and moves to PEND, discarding any pending branch.
  - EXE_Stall=0 in that cycle.
  - If EXC_Redirect and EXE_BranchTaken occur in the same cycle, the exception wins.
  - If EXC_Redirect arrives in PEND in the same cycle as IF_Ready=1, the branch handshake completes (IF_Flush=1) and the FSM stays in PEND with the exception target.
- Reset (any time, including mid-WAIT_DS or mid-PEND):
  - state=IDLE, TGT=RESET_TARGET, any pending redirect is dropped.
  - Outputs PC_RedirectValid=0, IF_Flush=0, EXE_Stall=0, counters=0.

## Timing
- Branch taken with delay slot already in ID (cycle N): PC_RedirectValid=1 at N+1. Earliest IF_Flush is at N+1.
- Branch taken without delay slot (cycle N): EXE_Stall=1 from N until the cycle ID_DelaySlotValid=1 (cycle M). PC_RedirectValid=1 at M+1.
- EXC_Redirect at N: PC_RedirectValid=1 at N+1.
- PC_RedirectValid stays asserted with a constant target until IF_Ready=1; it deasserts in the cycle after acceptance.
- Back-to-back redirects: the earliest next acceptance is one cycle after the previous acceptance (IDLE for at least one cycle) for branches, or the same cycle for an overriding exception.
- EXE_Stall and IF_Flush are combinational from state and inputs. PC_RedirectValid and PC_RedirectTarget are register-driven.

## Configuration
- BRANCH_REDIRECT_STAT_EN defined:
  - STAT_TakenCnt increments by 1 on every branch-caused transition out of IDLE.
  - STAT_WaitCnt increments by 1 each cycle that (EXE_Stall=1) or (PC_RedirectValid=1 and IF_Ready=0).
  - Both are 32-bit, wrap from 32'hFFFFFFFF to 0, and reset to 0. Exception redirects are not counted in STAT_TakenCnt.
- Not defined: counter logic is absent and both STAT ports are tied to 32'h0.

## Test plan
- Branch with delay slot ready: EXE_BranchTaken=1, target=32'hBFC0_0100, ID_DelaySlotValid=1, IF_Ready=1 -> next cycle PC_RedirectValid=1 with target 32'hBFC0_0100 and IF_Flush=1; cycle after that, valid=0 and state IDLE.
- Delay-slot wait: taken at N with ID_DelaySlotValid=0 for 3 cycles -> EXE_Stall=1 for N..N+2; DS valid at N+3 -> PC_RedirectValid=1 at N+4; STAT_WaitCnt=3 (macro on).
- Fetch backpressure: PEND with IF_Ready=0 for 4 cycles -> target held constant, IF_Flush=0; IF_Ready=1 on cycle 5 -> IF_Flush=1 and valid drops the next cycle.
- Exception priority: EXC_Redirect=1 with EXC_Target=32'hBFC0_0380 in the same cycle as a taken branch to 32'h8000_0000 -> redirect to 32'hBFC0_0380; STAT_TakenCnt unchanged.
- Reset mid-operation: resetn=0 while in WAIT_DS with EXE_Stall=1 -> all outputs 0 immediately and asynchronously; after release, state is IDLE and no redirect is issued.
- Counter wrap (macro on): preload STAT_TakenCnt to 32'hFFFFFFFF via forced stimulus, then one taken branch -> STAT_TakenCnt=0.
